// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth multiplier sequencer: one add/sub + arithmetic shift per clock,
// WIDTH iterations per operation, registered signed product with done pulse.
module booth_seq_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   multiplicand,
    input  logic signed [WIDTH-1:0]   multiplier,
    output logic                      busy,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic signed [WIDTH:0]     r_a;
    logic signed [WIDTH:0]     r_m;
    logic        [WIDTH-1:0]   r_q;
    logic                      r_q1;
    logic        [CNT_W-1:0]   r_cnt;
    logic signed [2*WIDTH-1:0] r_product;

    logic signed [WIDTH:0]     w_alu;
    logic signed [WIDTH:0]     w_a_nxt;
    logic        [WIDTH-1:0]   w_q_nxt;
    logic                      w_last;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_CALC;
            S_CALC:  if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != S_IDLE);
        done = (r_state == S_DONE);
    end

    // A is one bit wider than the operands so -2^(W-1) * -2^(W-1) cannot overflow
    always_comb begin
        case ({r_q[0], r_q1})
            2'b01:   w_alu = r_a + r_m;
            2'b10:   w_alu = r_a - r_m;
            default: w_alu = r_a;
        endcase
        w_a_nxt = {w_alu[WIDTH], w_alu[WIDTH:1]};
        w_q_nxt = {w_alu[0], r_q[WIDTH-1:1]};
        w_last  = (r_cnt == CNT_W'(1));
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            r_a       <= '0;
            r_q       <= '0;
            r_q1      <= 1'b0;
            r_m       <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_a   <= '0;
                        r_q   <= multiplier;
                        r_q1  <= 1'b0;
                        r_m   <= {multiplicand[WIDTH-1], multiplicand};
                        r_cnt <= CNT_W'(WIDTH);
                    end
                end
                S_CALC: begin
                    r_a   <= w_a_nxt;
                    r_q   <= w_q_nxt;
                    r_q1  <= r_q[0];
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (w_last) begin
                        r_product <= {w_a_nxt[WIDTH-1:0], w_q_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign product = r_product;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Bench for booth_seq_ctrl: random and directed products checked against plain
// signed multiplication, plus handshake timing, start-while-busy and clr abort.
module tb_booth_seq_ctrl;

    localparam int W = 8;

    logic                  clk = 1'b0;
    logic                  clr;
    logic                  start;
    logic signed [W-1:0]   mcand;
    logic signed [W-1:0]   mplier;
    logic                  busy;
    logic                  done;
    logic signed [2*W-1:0] product;

    int n_run  = 0;
    int n_fail = 0;

    booth_seq_ctrl #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .multiplicand(mcand),
        .multiplier  (mplier),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    // Launch one operation from IDLE and observe a fixed window after the accept edge.
    // Operand inputs are scrambled right after acceptance.
    task automatic run_op(input logic signed [W-1:0] m, input logic signed [W-1:0] q,
                          output logic signed [2*W-1:0] p, output int lat,
                          output int bcyc, output int dcnt);
        @(negedge clk);
        start  = 1'b1;
        mcand  = m;
        mplier = q;
        @(negedge clk);
        start  = 1'b0;
        mcand  = W'($urandom);
        mplier = W'($urandom);
        lat  = -1;
        bcyc = 0;
        dcnt = 0;
        for (int k = 1; k <= W + 4; k++) begin
            if (k > 1) @(negedge clk);
            if (busy === 1'b1) bcyc++;
            if (done === 1'b1) begin
                dcnt++;
                if (lat < 0) lat = k;
            end
        end
        p = product;
    endtask

    task automatic test_reset();
        clr    = 1'b1;
        start  = 1'b1;
        mcand  = W'($urandom);
        mplier = W'($urandom);
        @(negedge clk);
        @(negedge clk);
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_run++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_run++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL reset_product: got %h expected 0000", product); end
        clr   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        logic signed [2*W-1:0] p;
        int lat, bcyc, dcnt;
        run_op(8'sd7, 8'sd3, p, lat, bcyc, dcnt);
        n_run++;
        if (p !== 16'h0015) begin n_fail++; $display("FAIL basic_product: got %h expected 0015", p); end
        n_run++;
        if (lat !== W + 1) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, W + 1); end
        n_run++;
        if (bcyc !== W + 1) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected %0d", bcyc, W + 1); end
        n_run++;
        if (dcnt !== 1) begin n_fail++; $display("FAIL basic_done_count: got %0d expected 1", dcnt); end
        repeat (3) @(negedge clk);
        n_run++;
        if (product !== 16'h0015) begin n_fail++; $display("FAIL basic_hold: got %h expected 0015", product); end
    endtask

    task automatic test_signs();
        logic signed [W-1:0]   ms [5] = '{-8'sd5, 8'sd3, -8'sd128, 8'sd127, 8'sd0};
        logic signed [W-1:0]   qs [5] = '{8'sd3, -8'sd5, -8'sd128, -8'sd128, -8'sd1};
        logic        [2*W-1:0] ex [5] = '{16'hFFF1, 16'hFFF1, 16'h4000, 16'hC080, 16'h0000};
        logic signed [2*W-1:0] p;
        int lat, bcyc, dcnt;
        for (int i = 0; i < 5; i++) begin
            run_op(ms[i], qs[i], p, lat, bcyc, dcnt);
            n_run++;
            if (p !== ex[i]) begin
                n_fail++;
                $display("FAIL signs_%0d (%0d*%0d): got %h expected %h", i, ms[i], qs[i], p, ex[i]);
            end
        end
    endtask

    task automatic test_random();
        logic signed [W-1:0]   m, q;
        logic signed [2*W-1:0] p, exp_p;
        int lat, bcyc, dcnt;
        for (int i = 0; i < 24; i++) begin
            m = W'($urandom);
            q = W'($urandom);
            exp_p = m * q;
            run_op(m, q, p, lat, bcyc, dcnt);
            n_run++;
            if (p !== exp_p || lat !== W + 1 || dcnt !== 1) begin
                n_fail++;
                $display("FAIL random_%0d (%0d*%0d): got %h lat %0d dones %0d expected %h lat %0d dones 1",
                         i, m, q, p, lat, dcnt, exp_p, W + 1);
            end
        end
    endtask

    task automatic test_start_ignored();
        int dcnt = 0;
        @(negedge clk);
        start = 1'b1; mcand = 8'sd7; mplier = 8'sd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; mcand = 8'sd2; mplier = 8'sd2;
        @(negedge clk);
        start = 1'b0; mcand = -8'sd1; mplier = 8'sd5;
        for (int k = 4; k <= 16; k++) begin
            if (k > 4) @(negedge clk);
            if (done === 1'b1) dcnt++;
        end
        n_run++;
        if (dcnt !== 1) begin n_fail++; $display("FAIL ignore_done_count: got %0d expected 1", dcnt); end
        n_run++;
        if (product !== 16'h0015) begin n_fail++; $display("FAIL ignore_product: got %h expected 0015", product); end
    endtask

    task automatic test_clr_abort();
        logic signed [2*W-1:0] p;
        int lat, bcyc, dcnt;
        int aborted_dones = 0;
        @(negedge clk);
        start = 1'b1; mcand = 8'sd7; mplier = 8'sd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        n_run++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
        n_run++;
        if (product !== 16'h0000) begin n_fail++; $display("FAIL abort_product: got %h expected 0000", product); end
        for (int k = 0; k < W + 4; k++) begin
            if (done === 1'b1) aborted_dones++;
            @(negedge clk);
        end
        n_run++;
        if (aborted_dones !== 0) begin n_fail++; $display("FAIL abort_done: got %0d pulses expected 0", aborted_dones); end
        run_op(-8'sd2, 8'sd6, p, lat, bcyc, dcnt);
        n_run++;
        if (p !== 16'hFFF4) begin n_fail++; $display("FAIL abort_restart: got %h expected fff4", p); end
    endtask

    task automatic test_back_to_back();
        int last = -1;
        int pulses = 0;
        @(negedge clk);
        start = 1'b1; mcand = 8'sd10; mplier = -8'sd10;
        for (int c = 1; c <= 45; c++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                pulses++;
                n_run++;
                if (product !== 16'hFF9C) begin
                    n_fail++;
                    $display("FAIL b2b_product_%0d: got %h expected ff9c", pulses, product);
                end
                if (last >= 0) begin
                    n_run++;
                    if (c - last !== W + 2) begin
                        n_fail++;
                        $display("FAIL b2b_spacing_%0d: got %0d expected %0d", pulses, c - last, W + 2);
                    end
                end
                last = c;
            end
        end
        start = 1'b0;
        n_run++;
        if (pulses !== 4) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 4", pulses); end
        repeat (W + 4) @(negedge clk);
    endtask

    initial begin
        clr    = 1'b0;
        start  = 1'b0;
        mcand  = '0;
        mplier = '0;
        test_reset();
        test_basic();
        test_signs();
        test_random();
        test_start_ignored();
        test_clr_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
